// File: rtl/systolic_result_unloader_pkg.sv
// Shared definitions for the systolic result unloader: array geometry,
// default widths, drain FSM encoding and the PE flat-index helper.
package systolic_result_unloader_pkg;

    localparam int N          = 4;
    localparam int ACC_W_DEF  = 32;
    localparam int ELEM_W_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // PE k sits at row-major position k = N*row + col in the flat result bus.
    function automatic int pe_idx(input int row, input int col);
        return N * row + col;
    endfunction

endpackage

// File: rtl/systolic_result_unloader_sat_trunc.sv
// Combinational signed saturation of one ACC_W accumulator into an ELEM_W element;
// sat flags that the value did not fit and was clamped.
module sat_trunc #(
    parameter int ACC_W  = 32,
    parameter int ELEM_W = 16
) (
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ELEM_W-1:0] elem_out,
    output logic              sat
);

    // The value fits when every bit from the element sign bit upward matches.
    logic [ACC_W-ELEM_W:0] top_bits;

    always_comb begin
        top_bits = acc_in[ACC_W-1:ELEM_W-1];
        sat      = !((&top_bits) || (~|top_bits));
        if (!sat) begin
            elem_out = acc_in[ELEM_W-1:0];
        end else if (acc_in[ACC_W-1]) begin
            elem_out = {1'b1, {(ELEM_W-1){1'b0}}};
        end else begin
            elem_out = {1'b0, {(ELEM_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/systolic_result_unloader.sv
// Captures the systolic array result matrix on the rising edge of array_done,
// saturates it to ELEM_W elements and streams it out one packed row per handshake.
module systolic_result_unloader
    import systolic_result_unloader_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ELEM_W = ELEM_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  array_done,
    input  logic [N*N*ACC_W-1:0]  array_result,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [N*ELEM_W-1:0]   out_row,
    output logic [1:0]            out_row_idx,
    output logic                  out_last,
    output logic                  busy,
    output logic                  unload_done,
    output logic                  sat_flag,
    output logic                  overrun
);

    localparam int ROW_W = N * ELEM_W;

    logic [ELEM_W-1:0] elem_sat [N][N];
    logic [N*N-1:0]    sat_vec;
    logic [ROW_W-1:0]  cap_rows [N];

    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [ROW_W-1:0] buf_q [N];
    logic [ROW_W-1:0] buf_d [N];
    logic             done_q, done_d;
    logic             sat_flag_q, sat_flag_d;
    logic             overrun_q, overrun_d;
    logic             unload_done_q, unload_done_d;
    logic             capture;
    logic             last_hs;

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            sat_trunc #(
                .ACC_W  (ACC_W),
                .ELEM_W (ELEM_W)
            ) u_sat (
                .acc_in   (array_result[ACC_W*pe_idx(r, c) +: ACC_W]),
                .elem_out (elem_sat[r][c]),
                .sat      (sat_vec[pe_idx(r, c)])
            );
        end
    end

    // Column 0 lands in the most significant slot of each packed row.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            cap_rows[r] = '0;
            for (int c = 0; c < N; c++) begin
                cap_rows[r][(N-1-c)*ELEM_W +: ELEM_W] = elem_sat[r][c];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        buf_d         = buf_q;
        done_d        = array_done;
        sat_flag_d    = sat_flag_q;
        overrun_d     = overrun_q;
        unload_done_d = 1'b0;
        capture       = array_done && !done_q;
        last_hs       = (state_q == DRAIN) && out_ready && (row_q == 2'(N-1));

        case (state_q)
            IDLE: begin
                if (capture) begin
                    buf_d      = cap_rows;
                    sat_flag_d = |sat_vec;
                    row_d      = '0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (last_hs) begin
                    unload_done_d = 1'b1;
                    row_d         = '0;
                    // A new matrix arriving on the final handshake chains straight on.
                    if (capture) begin
                        buf_d      = cap_rows;
                        sat_flag_d = |sat_vec;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (out_ready) begin
                        row_d = row_q + 2'd1;
                    end
                    if (capture) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            row_q         <= '0;
            buf_q         <= '{default: '0};
            done_q        <= 1'b0;
            sat_flag_q    <= 1'b0;
            overrun_q     <= 1'b0;
            unload_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            buf_q         <= buf_d;
            done_q        <= done_d;
            sat_flag_q    <= sat_flag_d;
            overrun_q     <= overrun_d;
            unload_done_q <= unload_done_d;
        end
    end

    assign out_valid   = (state_q == DRAIN);
    assign out_row     = out_valid ? buf_q[row_q] : '0;
    assign out_row_idx = row_q;
    assign out_last    = out_valid && (row_q == 2'(N-1));
    assign busy        = out_valid;
    assign unload_done = unload_done_q;
    assign sat_flag    = sat_flag_q;
    assign overrun     = overrun_q;

endmodule
